// File: rtl/pipeline_skid_register_if.sv
// pipeline_skid_register_if
//   Valid/ready handshake bundle carrying one Size-bit word per transfer.
//   master: drives valid and data, receives ready.
//   slave:  receives valid and data, drives ready.
//   Signals:
//     valid  word on data is offered this cycle
//     ready  receiver accepts the offered word this cycle
//     data   Size-bit payload
interface pipeline_skid_register_if #(
  parameter int Size = 64
);
  logic            valid;
  logic            ready;
  logic [Size-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipeline_skid_register.sv
// pipeline_skid_register
//   Elastic two-entry pipeline stage (main + skid register). Passes one word per
//   cycle under valid/ready and registers the upstream ready so the ready path
//   is cut between the neighbouring stages.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous active-high reset (clears state and both registers)
//     flush  in   synchronous flush, discards held words, beats in_fire/out_fire
//     up     slave  side of the handshake: valid_i / ready_o / data_i
//     dn     master side of the handshake: valid_o / ready_i / data_o
//
//   state | meaning
//   ------+-------------------------------------------
//   EMPTY | no word held, data_o don't-care
//   BUSY  | main holds the oldest (only) word
//   FULL  | main holds oldest, skid holds the next one
module pipeline_skid_register #(
  parameter int Size = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  pipeline_skid_register_if.slave   up,
  pipeline_skid_register_if.master  dn
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [Size-1:0] main_q;
  logic [Size-1:0] skid_q;

  logic ready_int;
  logic valid_int;
  logic in_fire;
  logic out_fire;
  logic main_load;
  logic main_from_skid;
  logic skid_load;

  // Outputs decode from the state register only: no input-to-output path.
  assign ready_int = (state_q != FULL);
  assign valid_int = (state_q != EMPTY);

  assign up.ready = ready_int;
  assign dn.valid = valid_int;
  assign dn.data  = main_q;

  assign in_fire  = up.valid & ready_int;
  assign out_fire = valid_int & dn.ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      // Held words are abandoned in place; contents are don't-care once EMPTY.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // ready_o is low here, so only the drain side can fire.
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_load) begin
        main_q <= main_from_skid ? skid_q : up.data;
      end
      if (skid_load) begin
        skid_q <= up.data;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_skid_register.sv
module tb_pipeline_skid_register;
  localparam int Size = 64;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  pipeline_skid_register_if #(.Size(Size)) up_if ();
  pipeline_skid_register_if #(.Size(Size)) dn_if ();

  pipeline_skid_register #(.Size(Size)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .up    (up_if),
    .dn    (dn_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the words currently held by the stage, oldest first.
  logic [Size-1:0] q[$];

  // Drives one cycle of inputs (called 1 time unit after a rising edge),
  // waits for the next edge and advances the reference queue.
  task automatic drive(input logic v, input logic [Size-1:0] d, input logic r, input logic f);
    bit in_f;
    bit out_f;
    up_if.valid = v;
    up_if.data  = d;
    dn_if.ready = r;
    flush       = f;
    in_f  = v && (q.size() < 2);
    out_f = r && (q.size() > 0);
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
    end else begin
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(d);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    flush       = 1'b0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dn_if.valid); end
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", up_if.ready); end
    checks++; if (dn_if.data !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", dn_if.data); end
    up_if.valid = 1'bx;
    up_if.data  = 'x;
    dn_if.ready = 1'bx;
    flush       = 1'bx;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dn_if.valid, up_if.ready, dn_if.data} !== {1'b0, 1'b1, 64'h0}) begin
      errors++;
      $display("FAIL reset_xsafe got valid=%b ready=%b data=%h want 0 1 0", dn_if.valid, up_if.ready, dn_if.data);
    end
    reset       = 1'b0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;
    flush       = 1'b0;
    q.delete();
  endtask

  task automatic test_single_pass();
    drive(1'b1, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0);
    checks++; if (dn_if.valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", dn_if.valid); end
    checks++; if (dn_if.data !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL single_data got %h want deadbeefcafef00d", dn_if.data); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", dn_if.valid); end
  endtask

  task automatic test_streaming();
    logic [Size-1:0] w;
    int bad_ready = 0;
    int bad_data  = 0;
    for (int i = 0; i < 1000; i++) begin
      w = {$urandom, $urandom};
      if (up_if.ready !== 1'b1) bad_ready++;
      drive(1'b1, w, 1'b1, 1'b0);
      if (dn_if.valid !== 1'b1 || dn_if.data !== w) begin
        bad_data++;
        if (bad_data <= 5) $display("FAIL stream_word %0d got v=%b %h want 1 %h", i, dn_if.valid, dn_if.data, w);
      end
    end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL stream_ready got %0d stalls want 0", bad_ready); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL stream_data got %0d bad words want 0", bad_data); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", dn_if.valid); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 64'h1, 1'b0, 1'b0);
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b want 1", up_if.ready); end
    drive(1'b1, 64'h2, 1'b0, 1'b0);
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL bp_ready2 got %b want 0", up_if.ready); end
    checks++; if (dn_if.data !== 64'h1) begin errors++; $display("FAIL bp_hold got %h want 1", dn_if.data); end
    drive(1'b1, 64'h3, 1'b0, 1'b0);
    checks++; if (dn_if.data !== 64'h1 || up_if.ready !== 1'b0) begin errors++; $display("FAIL bp_stable got %h r=%b want 1 r=0", dn_if.data, up_if.ready); end
    drive(1'b1, 64'h3, 1'b1, 1'b0);
    checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== 64'h2) begin errors++; $display("FAIL bp_second got v=%b %h want 1 2", dn_if.valid, dn_if.data); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", dn_if.valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 64'hA, 1'b0, 1'b0);
    drive(1'b1, 64'hB, 1'b0, 1'b0);
    checks++; if (up_if.ready !== 1'b0 || dn_if.data !== 64'hA) begin errors++; $display("FAIL flush_full got r=%b %h want 0 a", up_if.ready, dn_if.data); end
    drive(1'b1, 64'hC, 1'b1, 1'b1);
    checks++; if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1) begin errors++; $display("FAIL flush_state got v=%b r=%b want 0 1", dn_if.valid, up_if.ready); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL flush_nocapture got %b want 0", dn_if.valid); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 64'hA, 1'b0, 1'b0);
    drive(1'b1, 64'hB, 1'b0, 1'b0);
    up_if.valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({dn_if.valid, up_if.ready, dn_if.data} !== {1'b0, 1'b1, 64'h0}) begin
      errors++;
      $display("FAIL midreset got valid=%b ready=%b data=%h want 0 1 0", dn_if.valid, up_if.ready, dn_if.data);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    drive(1'b1, 64'h5, 1'b0, 1'b0);
    checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== 64'h5) begin errors++; $display("FAIL midreset_resume got v=%b %h want 1 5", dn_if.valid, dn_if.data); end
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int bad = 0;
    logic v;
    logic r;
    logic f;
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 6);
      f = ($urandom_range(0, 19) == 0);
      drive(v, {$urandom, $urandom}, r, f);
      if (dn_if.valid !== (q.size() > 0) || up_if.ready !== (q.size() < 2) ||
          (q.size() > 0 && dn_if.data !== q[0])) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random_cycle %0d got v=%b r=%b %h want depth %0d head %h",
                   i, dn_if.valid, up_if.ready, dn_if.data, q.size(), (q.size() > 0) ? q[0] : '0);
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL random_total got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
